// File: rtl/or_frame_acc_pkg.sv
// Shared types and defaults for the OR frame accumulator and its bench predictor.
package or_frame_acc_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W   = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_CNT_W-1:0] count;
    logic                 any;
    logic                 overflow;
  } summary_t;

endpackage

// File: rtl/or_frame_acc_counter.sv
// Saturating beat counter: clear, load-1, increment, and a flag for "next beat lands on MAX_LEN".
module or_frame_acc_counter #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);

  // The frame closer needs to know one beat ahead, so the flag looks at cnt+1.
  assign at_max = (cnt == CNT_W'(MAX_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (load1)               cnt <= CNT_W'(1);
    else if (inc && cnt != MAX_C) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/or_frame_accumulator.sv
// Sticky-OR frame reducer: one registered summary per frame (closed by last or MAX_LEN).
// Optional synchronous clear port enabled by OR_FRAME_ACC_CLEAR_EN.
module or_frame_accumulator
  import or_frame_acc_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef OR_FRAME_ACC_CLEAR_EN
  input  logic             clr,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_any,
  output logic             out_overflow
);

  state_e           state;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             at_max, accept, close, drain, clr_i;

`ifdef OR_FRAME_ACC_CLEAR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif

  assign accept  = in_valid && in_ready;
  assign drain   = (state == HOLD) && out_ready;
  assign acc_nxt = (state == IDLE) ? in_data : (acc | in_data);
  assign cnt_nxt = cnt + CNT_W'(1);
  // cnt is 0 in IDLE, so at_max also covers MAX_LEN == 1 on the first beat.
  assign close   = accept && (in_last || at_max);

  or_frame_acc_counter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_i || drain),
    .load1  (accept && state == IDLE),
    .inc    (accept && state == ACCUM),
    .cnt    (cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_any      <= 1'b0;
      out_overflow <= 1'b0;
    end else if (clr_i) begin
      state        <= IDLE;
      acc          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_any      <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc <= acc_nxt;
            if (close) begin
              state        <= HOLD;
              in_ready     <= 1'b0;
              out_valid    <= 1'b1;
              out_data     <= acc_nxt;
              out_count    <= cnt_nxt;
              out_any      <= |acc_nxt;
              out_overflow <= ~in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state        <= IDLE;
            acc          <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_any      <= 1'b0;
            out_overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_frame_accumulator.sv
// Bench for or_frame_accumulator: table vectors, directed corner sequences, random frames vs. a list-splitting model.
module tb_or_frame_accumulator;
  import or_frame_acc_pkg::*;

  localparam int W  = 8;
  localparam int ML = 16;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_any, out_overflow;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef OR_FRAME_ACC_CLEAR_EN
  logic          clr = 1'b0;
`endif

  or_frame_accumulator #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef OR_FRAME_ACC_CLEAR_EN
    .clr          (clr),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_any      (out_any),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  summary_t exp_q[$];
  bit       rand_done;

  typedef struct {
    int           n;
    logic [W-1:0] d[4];
    logic [W-1:0] exp_data;
    int           exp_cnt;
    logic         exp_any;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic summary_t mk(input logic [W-1:0] d, input int n, input bit ovf);
    summary_t s;
    s.data     = d;
    s.count    = CW'(n);
    s.any      = |d;
    s.overflow = ovf;
    return s;
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input logic lst);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic accept_summary();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_summary(input string tag, input logic [W-1:0] d, input int n, input logic ovf);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_data"},  32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(n));
    chk({tag, "_any"},   32'(out_any), 32'(|d));
    chk({tag, "_ovf"},   32'(out_overflow), 32'(ovf));
    chk({tag, "_rdy"},   32'(in_ready), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{n: 1, d: '{8'h05, 8'h00, 8'h00, 8'h00}, exp_data: 8'h05, exp_cnt: 1, exp_any: 1'b1};
    vt[1] = '{n: 3, d: '{8'h01, 8'h10, 8'h80, 8'h00}, exp_data: 8'h91, exp_cnt: 3, exp_any: 1'b1};
    vt[2] = '{n: 4, d: '{8'h00, 8'h00, 8'h00, 8'h00}, exp_data: 8'h00, exp_cnt: 4, exp_any: 1'b0};
    vt[3] = '{n: 2, d: '{8'h3C, 8'hC3, 8'h00, 8'h00}, exp_data: 8'hFF, exp_cnt: 2, exp_any: 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_count", 32'(out_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));

    // table-driven frames
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < vt[i].n; b++) send_beat(vt[i].d[b], b == vt[i].n - 1);
      chk("tbl_data", 32'(out_data), 32'(vt[i].exp_data));
      chk("tbl_count", 32'(out_count), 32'(vt[i].exp_cnt));
      chk("tbl_any", 32'(out_any), 32'(vt[i].exp_any));
      chk("tbl_valid", 32'(out_valid), 32'(1));
      chk("tbl_ovf", 32'(out_overflow), 32'(0));
      chk("tbl_rdy", 32'(in_ready), 32'(0));
      accept_summary();
      chk("tbl_clr_valid", 32'(out_valid), 32'(0));
      chk("tbl_clr_data", 32'(out_data), 32'(0));
      chk("tbl_rdy_back", 32'(in_ready), 32'(1));
    end

    // overflow close, then backpressure with a beat waiting
    for (int b = 0; b < ML; b++) send_beat(8'h01, 1'b0);
    chk_summary("ovf", 8'h01, ML, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(in_ready), 32'(0));
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_data", 32'(out_data), 32'(8'h01));
      chk("bp_count", 32'(out_count), 32'(ML));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_summary("after_ovf", 8'h01, 1, 1'b0);
    accept_summary();

    // last exactly at MAX_LEN is a normal close
    for (int b = 0; b < ML - 1; b++) send_beat(8'h02, 1'b0);
    send_beat(8'h40, 1'b1);
    chk_summary("exact_max", 8'h42, ML, 1'b0);
    accept_summary();

    // reset mid-frame
    send_beat(8'h0F, 1'b0);
    send_beat(8'h0F, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_data", 32'(out_data), 32'(0));
    chk("midrst_count", 32'(out_count), 32'(0));
    chk("midrst_rdy", 32'(in_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(8'hF0, 1'b1);
    chk_summary("post_rst", 8'hF0, 1, 1'b0);

    // reset while holding a summary
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("holdrst_valid", 32'(out_valid), 32'(0));
    chk("holdrst_any", 32'(out_any), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(8'h33, 1'b1);
    chk_summary("post_holdrst", 8'h33, 1, 1'b0);
    accept_summary();

    // random packets; the model splits each packet into MAX_LEN-sized frames
    rand_done = 1'b0;
    fork
      begin
        int           len, n, t;
        logic [W-1:0] acc, d;
        bit           lst;
        for (int p = 0; p < 40; p++) begin
          len = $urandom_range(1, 20);
          acc = '0;
          n   = 0;
          for (int b = 0; b < len; b++) begin
            d   = W'($urandom) & W'($urandom);
            lst = (b == len - 1);
            acc = acc | d;
            n++;
            if (lst || n == ML) begin
              exp_q.push_back(mk(acc, n, !lst));
              acc = '0;
              n   = 0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(d, lst);
          end
        end
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
          @(negedge clk);
          t++;
        end
        if (exp_q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL rand_drain: %0d summaries outstanding, expected 0", exp_q.size());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
      end
      begin
        summary_t cur, prev, e;
        bit       pend;
        pend = 1'b0;
        prev = '0;
        while (!rand_done) begin
          @(negedge clk);
          cur = {out_data, out_count, out_any, out_overflow};
          if (pend) chk("rand_stable", 32'(cur), 32'(prev));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rand_extra: got summary %0h, expected none", cur);
            end else begin
              e = exp_q.pop_front();
              chk("rand_summary", 32'(cur), 32'(e));
            end
            pend = 1'b0;
          end else begin
            pend = out_valid;
            prev = cur;
          end
        end
      end
    join

    @(negedge clk);
    chk("end_valid", 32'(out_valid), 32'(0));
    chk("end_rdy", 32'(in_ready), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
